// File: rtl/lvdc_mem_pkg.sv
// Shared constants for the LVDC main-memory arbiter: default bus widths,
// transaction state encoding and requester ids.
package lvdc_mem_pkg;

  localparam int ADDR_W_DFLT = 15;
  localparam int WORD_W_DFLT = 26;
  localparam int SYL_W_DFLT  = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_IO  = 1'b1;

endpackage

// File: rtl/lvdc_mem_prio.sv
// Requester priority for the memory arbiter: the CPU wins by default, and the
// I/O channel wins once it has been passed over STARVE_MAX times in a row.
module lvdc_mem_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic io_req,
  input  logic grant_stb,
  output logic win_io,
  output logic grant_any
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved   = (starve_cnt >= CNT_MAX);
  assign win_io    = io_req && (!cpu_req || starved);
  assign grant_any = cpu_req || io_req;

  // Only CPU grants made over a waiting I/O request count as starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_stb) begin
      if (win_io) begin
        starve_cnt <= '0;
      end else if (io_req && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvdc_mem_arbiter.sv
// Shares the syllable-wide main memory bus between CPU and I/O channel,
// splitting each word access into lo/hi syllable phases with wait states.
// Optional odd-parity generation/checking is enabled by LVDC_MEM_PARITY_EN.
module lvdc_mem_arbiter
  import lvdc_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DFLT,
  parameter int WORD_W      = WORD_W_DFLT,
  parameter int SYL_W       = SYL_W_DFLT,
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [WORD_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [WORD_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [WORD_W-1:0] io_rdata,
  output logic [ADDR_W:0]   mem_addr,
  output logic [SYL_W-1:0]  mem_wdata,
  input  logic [SYL_W-1:0]  mem_rdata,
  output logic              mem_par_o,
  input  logic              mem_par_i,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              busy,
  output logic              parity_err
);

  localparam int PH_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q;
  logic              id_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [SYL_W-1:0]  lo_q;
  logic [SYL_W-1:0]  syl_wdata;
  logic              win_io, grant_any, grant_stb, phase_last, in_phase, read_cap;

  lvdc_mem_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .io_req    (io_req),
    .grant_stb (grant_stb),
    .win_io    (win_io),
    .grant_any (grant_any)
  );

  assign grant_stb  = (state_q == ST_IDLE) && grant_any;
  assign phase_last = (phase_q == '0);
  assign in_phase   = (state_q == ST_LO) || (state_q == ST_HI);
  assign read_cap   = in_phase && phase_last && !we_q;
  assign syl_wdata  = (state_q == ST_HI) ? wdata_q[WORD_W-1:SYL_W] : wdata_q[SYL_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_any)  state_d = ST_LO;
      ST_LO:   if (phase_last) state_d = ST_HI;
      ST_HI:   if (phase_last) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are frozen at grant so requesters may change inputs freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      phase_q <= '0;
    end else if (grant_stb) begin
      id_q    <= win_io ? REQ_IO : REQ_CPU;
      we_q    <= win_io ? io_we : cpu_we;
      addr_q  <= win_io ? io_addr : cpu_addr;
      wdata_q <= win_io ? io_wdata : cpu_wdata;
      phase_q <= PH_LOAD;
    end else if (in_phase) begin
      phase_q <= phase_last ? PH_LOAD : phase_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q      <= '0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
    end else if (read_cap) begin
      if (state_q == ST_LO) begin
        lo_q <= mem_rdata;
      end else if (id_q == REQ_IO) begin
        io_rdata <= {mem_rdata, lo_q};
      end else begin
        cpu_rdata <= {mem_rdata, lo_q};
      end
    end
  end

  // The last cycle of a write phase releases mem_we_n to give address/data hold.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    cpu_ack   = (state_q == ST_ACK) && (id_q == REQ_CPU);
    io_ack    = (state_q == ST_ACK) && (id_q == REQ_IO);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_par_o = 1'b0;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    if (in_phase) begin
      mem_addr = {addr_q, (state_q == ST_HI)};
      if (we_q) begin
        mem_wdata = syl_wdata;
        mem_we_n  = ~((phase_q != '0) || (WAIT_STATES == 0));
`ifdef LVDC_MEM_PARITY_EN
        mem_par_o = ~^syl_wdata;
`endif
      end else begin
        mem_oe_n = 1'b0;
      end
    end
  end

`ifdef LVDC_MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (read_cap && !(^{mem_rdata, mem_par_i})) begin
      parity_err <= 1'b1;
    end
  end
`else
  logic unused_par;
  assign unused_par = &{1'b0, mem_par_i};
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_lvdc_mem_arbiter.sv
// Directed bench for lvdc_mem_arbiter: table-driven word transactions plus
// reset-abort, starvation and parity sequences.
module tb_lvdc_mem_arbiter;

  localparam int WS = 1;
  localparam int SM = 4;
  localparam int EXP_LAT = 2 * (WS + 1) + 1;
`ifdef LVDC_MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    bit          is_io;
    bit          we;
    logic [14:0] addr;
    logic [25:0] wdata;
    logic [12:0] mem_lo;
    logic [12:0] mem_hi;
    logic [25:0] exp_rdata;
    logic [15:0] exp_addr_lo;
    logic [15:0] exp_addr_hi;
    logic [12:0] exp_wlo;
    logic [12:0] exp_whi;
    bit          exp_par_lo;
    int          exp_we_lows;
    int          exp_oe_lows;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, io_req = 1'b0, io_we = 1'b0;
  logic [14:0] cpu_addr = '0, io_addr = '0;
  logic [25:0] cpu_wdata = '0, io_wdata = '0;
  logic        cpu_ack, io_ack, mem_par_o, mem_par_i, mem_oe_n, mem_we_n, busy, parity_err;
  logic [25:0] cpu_rdata, io_rdata;
  logic [15:0] mem_addr;
  logic [12:0] mem_wdata, mem_rdata;
  logic [12:0] mem_lo_v = '0, mem_hi_v = '0;
  logic        par_force = 1'b0;

  int total = 0;
  int bad = 0;
  vec_t vecs[6];
  vec_t pv_bad, pv_clean, rv_restart;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr[0] ? mem_hi_v : mem_lo_v;
  assign mem_par_i = par_force ? 1'b1 : ~^mem_rdata;

  lvdc_mem_arbiter #(.WAIT_STATES(WS), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_par_o(mem_par_o), .mem_par_i(mem_par_i),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .busy(busy), .parity_err(parity_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One complete word transaction, observed at negedges after the request.
  task automatic applyStimulus(input vec_t v);
    int          lat = 0, we_lows = 0, oe_lows = 0, other_ack = 0;
    logic        got = 1'b0;
    logic [15:0] a_lo = '0, a_hi = '0;
    logic [12:0] w_lo = '0, w_hi = '0;
    logic        p_lo = 1'b0;
    logic [25:0] rd = '0;
    @(negedge clk);
    mem_lo_v = v.mem_lo;
    mem_hi_v = v.mem_hi;
    if (v.is_io) begin
      io_req = 1'b1; io_we = v.we; io_addr = v.addr; io_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      lat = n;
      if (!mem_we_n) we_lows++;
      if (!mem_oe_n) oe_lows++;
      if (n == 1) begin a_lo = mem_addr; w_lo = mem_wdata; p_lo = mem_par_o; end
      if (n == 3) begin a_hi = mem_addr; w_hi = mem_wdata; end
      if (v.is_io ? cpu_ack : io_ack) other_ack++;
      if (v.is_io ? io_ack : cpu_ack) begin
        got = 1'b1;
        rd = v.is_io ? io_rdata : cpu_rdata;
        cpu_req = 1'b0;
        io_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    io_req = 1'b0;
    checkOutput({v.name, ".ack_seen"}, 32'(got), 32'd1);
    checkOutput({v.name, ".latency"}, 32'(lat), 32'(EXP_LAT));
    checkOutput({v.name, ".rdata"}, 32'(rd), 32'(v.exp_rdata));
    checkOutput({v.name, ".addr_lo"}, 32'(a_lo), 32'(v.exp_addr_lo));
    checkOutput({v.name, ".addr_hi"}, 32'(a_hi), 32'(v.exp_addr_hi));
    checkOutput({v.name, ".we_lows"}, 32'(we_lows), 32'(v.exp_we_lows));
    checkOutput({v.name, ".oe_lows"}, 32'(oe_lows), 32'(v.exp_oe_lows));
    checkOutput({v.name, ".other_ack"}, 32'(other_ack), 32'd0);
    if (v.we) begin
      checkOutput({v.name, ".wdata_lo"}, 32'(w_lo), 32'(v.exp_wlo));
      checkOutput({v.name, ".wdata_hi"}, 32'(w_hi), 32'(v.exp_whi));
      checkOutput({v.name, ".par_lo"}, 32'(p_lo), 32'(PAR_ON ? v.exp_par_lo : 1'b0));
    end
    @(negedge clk);
    checkOutput({v.name, ".idle_busy"}, 32'(busy), 32'd0);
    checkOutput({v.name, ".idle_acks"}, 32'({cpu_ack, io_ack}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got running want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   acks, last_n, n, bad_after_rst;
    bit   pending;
    bit   order[10];
    int   gaps[10];
    bit   exp_order[10];

    vecs[0] = '{"cpu_rd", 1'b0, 1'b0, 15'h1234, 26'h0, 13'h0ABC, 13'h1555, 26'h2AAAABC,
                16'h2468, 16'h2469, 13'h0, 13'h0, 1'b0, 0, 4};
    vecs[1] = '{"cpu_wr", 1'b0, 1'b1, 15'h7FFF, 26'h3FFFFFF, 13'h0, 13'h0, 26'h2AAAABC,
                16'hFFFE, 16'hFFFF, 13'h1FFF, 13'h1FFF, 1'b0, 2, 0};
    vecs[2] = '{"io_rd", 1'b1, 1'b0, 15'h0001, 26'h0, 13'h1FFF, 13'h0000, 26'h0001FFF,
                16'h0002, 16'h0003, 13'h0, 13'h0, 1'b0, 0, 4};
    vecs[3] = '{"io_wr", 1'b1, 1'b1, 15'h4000, 26'h2AAAAAA, 13'h0, 13'h0, 26'h0001FFF,
                16'h8000, 16'h8001, 13'h0AAA, 13'h1555, 1'b1, 2, 0};
    vecs[4] = '{"cpu_rd0", 1'b0, 1'b0, 15'h0000, 26'h0, 13'h0000, 13'h1FFF, 26'h3FFE000,
                16'h0000, 16'h0001, 13'h0, 13'h0, 1'b0, 0, 4};
    vecs[5] = '{"cpu_rd1", 1'b0, 1'b0, 15'h2AAA, 26'h0, 13'h1234, 13'h0F0F, 26'h1E1F234,
                16'h5554, 16'h5555, 13'h0, 13'h0, 1'b0, 0, 4};
    rv_restart = '{"restart_rd", 1'b0, 1'b0, 15'h0555, 26'h0, 13'h0111, 13'h0222, 26'h0444111,
                   16'h0AAA, 16'h0AAB, 13'h0, 13'h0, 1'b0, 0, 4};
    pv_bad = '{"par_bad_rd", 1'b0, 1'b0, 15'h0010, 26'h0, 13'h0001, 13'h0001, 26'h0002001,
               16'h0020, 16'h0021, 13'h0, 13'h0, 1'b0, 0, 4};
    pv_clean = '{"par_clean_rd", 1'b0, 1'b0, 15'h0011, 26'h0, 13'h0003, 13'h0007, 26'h000E003,
                 16'h0022, 16'h0023, 13'h0, 13'h0, 1'b0, 0, 4};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst.strobes", 32'({mem_oe_n, mem_we_n}), 32'h3);
    checkOutput("rst.mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst.flags", 32'({busy, cpu_ack, io_ack, parity_err, mem_par_o}), 32'd0);
    checkOutput("rst.cpu_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("rst.io_rdata", 32'(io_rdata), 32'd0);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during write hi phase");
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0123; cpu_wdata = 26'h1234567;
    repeat (3) @(negedge clk);
    checkOutput("rstmid.pre_we_n", 32'(mem_we_n), 32'd0);
    checkOutput("rstmid.pre_addr", 32'(mem_addr), 32'h0247);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.we_n", 32'(mem_we_n), 32'd1);
    checkOutput("rstmid.busy", 32'(busy), 32'd0);
    checkOutput("rstmid.acks", 32'({cpu_ack, io_ack}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_after_rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack || io_ack || !mem_we_n || busy) bad_after_rst++;
    end
    checkOutput("rstmid.quiet_after", 32'(bad_after_rst), 32'd0);
    applyStimulus(rv_restart);

    $display("[TB] starvation guard");
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
    io_req = 1'b1; io_we = 1'b0; io_addr = 15'h0200;
    acks = 0; last_n = 0; n = 0; pending = 1'b0;
    while (acks < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (pending) begin
        checkOutput("starve.idle_gap", 32'(busy), 32'd0);
        pending = 1'b0;
      end
      if (cpu_ack || io_ack) begin
        checkOutput("starve.single_ack", 32'(cpu_ack & io_ack), 32'd0);
        order[acks] = io_ack;
        gaps[acks] = n - last_n;
        last_n = n;
        acks++;
        pending = 1'b1;
      end
    end
    cpu_req = 1'b0;
    io_req = 1'b0;
    checkOutput("starve.ack_count", 32'(acks), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < acks) checkOutput($sformatf("starve.order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      if (k > 0 && k < acks) checkOutput($sformatf("starve.period%0d", k), 32'(gaps[k]), 32'(2 * (WS + 1) + 2));
    end
    @(negedge clk);

    $display("[TB] parity");
    checkOutput("par.clean_so_far", 32'(parity_err), 32'd0);
    par_force = 1'b1;
    applyStimulus(pv_bad);
    par_force = 1'b0;
`ifdef LVDC_MEM_PARITY_EN
    checkOutput("par.err_set", 32'(parity_err), 32'd1);
    applyStimulus(pv_clean);
    checkOutput("par.err_sticky", 32'(parity_err), 32'd1);
`else
    checkOutput("par.err_disabled", 32'(parity_err), 32'd0);
    applyStimulus(pv_clean);
    checkOutput("par.err_still_zero", 32'(parity_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
